// File: rtl/alu_seq_engine.sv
`timescale 1ns/1ps
// alu_seq_engine
//   Multi-cycle ALU sequencer. Operand A and then operand B are captured from
//   data_in on successive step pulses. The selected operation then executes:
//   single-cycle ops take one edge, while MUL/DIV/MOD iterate WIDTH times.
//   The result and the status flags are held until the next step.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   LOAD_A | waiting for step to capture operand A
//   LOAD_B | waiting for step to capture operand B and latch op
//   EXEC   | computing (1 cycle, or WIDTH cycles for MUL/DIV/MOD)
//   DONE   | result/flags valid; step clears everything and returns to LOAD_A
//
// Ports
//   clk, reset (async, active-high), clear (sync, active-high)
//   step    : single-cycle advance pulse
//   op      : operation select, sampled on the B-capture edge
//   data_in : operand bus, sampled on the A/B-capture edges
//   reg_a, reg_b, result : captured operands and result register
//   phase   : current state encoding, busy (EXEC), done (DONE)
//   flag_zero/carry/ovf/err : status of the last operation
module alu_seq_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             step,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       phase,
    output logic             busy,
    output logic             done,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_ovf,
    output logic             flag_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_SAT  = CW'(WIDTH);
    localparam logic [WIDTH-1:0] W_VAL    = WIDTH'(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;
    localparam logic [3:0] OP_MOD = 4'd10;
    localparam logic [3:0] OP_CMP = 4'd11;

    typedef enum logic [1:0] {
        S_LOAD_A = 2'b00,
        S_LOAD_B = 2'b01,
        S_EXEC   = 2'b10,
        S_DONE   = 2'b11
    } state_t;

    state_t state, state_nx;

    logic [3:0]       op_q;
    logic [CW-1:0]    cnt;
    // Iteration scratch: product high/low halves for MUL,
    // partial remainder / shifting quotient for DIV and MOD.
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;

    logic             div_zero;
    logic             is_multi;
    logic             cnt_last;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;
    logic             sc_ovf;
    logic             sc_err;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;
    logic [WIDTH-1:0] it_hi;
    logic [WIDTH-1:0] it_lo;
    logic [WIDTH-1:0] fin_res;
    logic             fin_carry;

    assign phase = state;
    assign busy  = (state == S_EXEC);
    assign done  = (state == S_DONE);

    assign div_zero = (reg_b == '0);
    assign is_multi = (op_q == OP_MUL) ||
                      (((op_q == OP_DIV) || (op_q == OP_MOD)) && !div_zero);
    assign cnt_last = (cnt == CNT_LAST);

    assign add_sum = {1'b0, reg_a} + {1'b0, reg_b};
    assign sub_res = reg_a - reg_b;

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_err   = 1'b0;
        case (op_q)
            OP_ADD: begin
                sc_res   = add_sum[WIDTH-1:0];
                sc_carry = add_sum[WIDTH];
                sc_ovf   = (reg_a[WIDTH-1] == reg_b[WIDTH-1]) &&
                           (add_sum[WIDTH-1] != reg_a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res   = sub_res;
                sc_carry = (reg_a < reg_b);
                sc_ovf   = (reg_a[WIDTH-1] != reg_b[WIDTH-1]) &&
                           (sub_res[WIDTH-1] != reg_a[WIDTH-1]);
            end
            OP_AND: sc_res = reg_a & reg_b;
            OP_OR:  sc_res = reg_a | reg_b;
            OP_XOR: sc_res = reg_a ^ reg_b;
            OP_NOT: sc_res = ~reg_a;
            OP_SHL: sc_res = (reg_b >= W_VAL) ? '0 : (reg_a << reg_b);
            OP_SHR: sc_res = (reg_b >= W_VAL) ? '0 : (reg_a >> reg_b);
            // Only reached here when B is zero; non-zero B iterates.
            OP_DIV: begin
                sc_res = '1;
                sc_err = 1'b1;
            end
            OP_MOD: begin
                sc_res = reg_a;
                sc_err = 1'b1;
            end
            OP_CMP: sc_res = {{(WIDTH-1){1'b0}}, (reg_a < reg_b)};
            default: sc_err = 1'b1;
        endcase
    end

    // One shift-add multiply step: add A when the multiplier LSB is set,
    // then shift {carry, hi, lo} right by one.
    assign mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, reg_a} : '0);
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], work_lo[WIDTH-1:1]};

    // One restoring divide step. The remainder is always below B, so the
    // subtraction result fits back into WIDTH bits.
    assign div_shift = {work_hi, work_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, reg_b});
    assign div_hi    = div_ge ? (div_shift[WIDTH-1:0] - reg_b) : div_shift[WIDTH-1:0];
    assign div_lo    = {work_lo[WIDTH-2:0], div_ge};

    assign it_hi     = (op_q == OP_MUL) ? mul_hi : div_hi;
    assign it_lo     = (op_q == OP_MUL) ? mul_lo : div_lo;
    assign fin_res   = (op_q == OP_MOD) ? div_hi : it_lo;
    assign fin_carry = (op_q == OP_MUL) && (mul_hi != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_LOAD_A;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_LOAD_A: if (step) state_nx = S_LOAD_B;
            S_LOAD_B: if (step) state_nx = S_EXEC;
            S_EXEC:   if (!is_multi || cnt_last) state_nx = S_DONE;
            S_DONE:   if (step) state_nx = S_LOAD_A;
            default:  state_nx = S_LOAD_A;
        endcase
        if (clear) state_nx = S_LOAD_A;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_a      <= '0;
            reg_b      <= '0;
            result     <= '0;
            op_q       <= '0;
            cnt        <= '0;
            work_hi    <= '0;
            work_lo    <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
            flag_err   <= 1'b0;
        end else if (clear) begin
            reg_a      <= '0;
            reg_b      <= '0;
            result     <= '0;
            op_q       <= '0;
            cnt        <= '0;
            work_hi    <= '0;
            work_lo    <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
            flag_err   <= 1'b0;
        end else begin
            case (state)
                S_LOAD_A: begin
                    if (step) reg_a <= data_in;
                end
                S_LOAD_B: begin
                    if (step) begin
                        reg_b   <= data_in;
                        op_q    <= op;
                        cnt     <= '0;
                        work_hi <= '0;
                        // MUL shifts the multiplier B; DIV/MOD shift the dividend A.
                        work_lo <= (op == OP_MUL) ? data_in : reg_a;
                    end
                end
                S_EXEC: begin
                    if (!is_multi) begin
                        result     <= sc_res;
                        flag_zero  <= (sc_res == '0);
                        flag_carry <= sc_carry;
                        flag_ovf   <= sc_ovf;
                        flag_err   <= sc_err;
                        cnt        <= '0;
                    end else begin
                        work_hi <= it_hi;
                        work_lo <= it_lo;
                        if (cnt_last) begin
                            result     <= fin_res;
                            flag_zero  <= (fin_res == '0);
                            flag_carry <= fin_carry;
                            flag_ovf   <= 1'b0;
                            flag_err   <= 1'b0;
                            cnt        <= '0;
                        end else if (cnt != CNT_SAT) begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (step) begin
                        reg_a      <= '0;
                        reg_b      <= '0;
                        result     <= '0;
                        flag_zero  <= 1'b0;
                        flag_carry <= 1'b0;
                        flag_ovf   <= 1'b0;
                        flag_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_engine.sv
`timescale 1ns/1ps
// Testbench for alu_seq_engine at WIDTH 8, 16 and 4. Stimulus pushes the
// expected outcome of each sequence into a queue; a negedge monitor pops and
// compares whenever a DUT's done rises.
module tb_alu_seq_engine;

    typedef struct {
        int         k;
        longint     res;
        logic [3:0] flg;   // {zero, carry, ovf, err}
        int         lat;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        clr;
    logic [2:0]  stp;
    logic [3:0]  opv;
    logic [15:0] din;

    logic [7:0]  ra8, rb8, res8;
    logic [15:0] ra16, rb16, res16;
    logic [3:0]  ra4, rb4, res4;
    logic [1:0]  ph [3];
    logic [2:0]  bsy, dn, fz, fc, fv, fe;

    logic [15:0] o_ra  [3];
    logic [15:0] o_rb  [3];
    logic [15:0] o_res [3];

    int   total  = 0;
    int   passed = 0;
    exp_t sbq[$];

    alu_seq_engine #(.WIDTH(8)) u_w8 (
        .clk(clk), .reset(reset), .clear(clr), .step(stp[0]), .op(opv),
        .data_in(din[7:0]), .reg_a(ra8), .reg_b(rb8), .result(res8),
        .phase(ph[0]), .busy(bsy[0]), .done(dn[0]), .flag_zero(fz[0]),
        .flag_carry(fc[0]), .flag_ovf(fv[0]), .flag_err(fe[0])
    );

    alu_seq_engine #(.WIDTH(16)) u_w16 (
        .clk(clk), .reset(reset), .clear(clr), .step(stp[1]), .op(opv),
        .data_in(din), .reg_a(ra16), .reg_b(rb16), .result(res16),
        .phase(ph[1]), .busy(bsy[1]), .done(dn[1]), .flag_zero(fz[1]),
        .flag_carry(fc[1]), .flag_ovf(fv[1]), .flag_err(fe[1])
    );

    alu_seq_engine #(.WIDTH(4)) u_w4 (
        .clk(clk), .reset(reset), .clear(clr), .step(stp[2]), .op(opv),
        .data_in(din[3:0]), .reg_a(ra4), .reg_b(rb4), .result(res4),
        .phase(ph[2]), .busy(bsy[2]), .done(dn[2]), .flag_zero(fz[2]),
        .flag_carry(fc[2]), .flag_ovf(fv[2]), .flag_err(fe[2])
    );

    assign o_ra[0]  = 16'(ra8);
    assign o_ra[1]  = ra16;
    assign o_ra[2]  = 16'(ra4);
    assign o_rb[0]  = 16'(rb8);
    assign o_rb[1]  = rb16;
    assign o_rb[2]  = 16'(rb4);
    assign o_res[0] = 16'(res8);
    assign o_res[1] = res16;
    assign o_res[2] = 16'(res4);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wid(input int k);
        return (k == 0) ? 8 : ((k == 1) ? 16 : 4);
    endfunction

    task automatic chk(input string nm, input longint act, input longint expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    endtask

    // Reference model: plain integer arithmetic on unsigned values, with
    // signed overflow judged by reinterpreting operands as two's complement.
    function automatic exp_t model(input int w, input longint a, input longint b, input int op);
        exp_t   r;
        longint full, m, half, sa, sb, s, v;
        bit     c, ov, er;
        full = longint'(1) << w;
        m    = full - 1;
        half = full >> 1;
        sa   = (a >= half) ? a - full : a;
        sb   = (b >= half) ? b - full : b;
        c = 0; ov = 0; er = 0; v = 0;
        r.k = 0; r.lat = 1;
        case (op)
            0: begin v = a + b; c = (v >= full); s = sa + sb; ov = (s >= half) || (s < -half); v = v & m; end
            1: begin v = (a - b) & m; c = (a < b); s = sa - sb; ov = (s >= half) || (s < -half); end
            2: v = a & b;
            3: v = a | b;
            4: v = a ^ b;
            5: v = (~a) & m;
            6: v = (b >= w) ? 0 : ((a << b) & m);
            7: v = (b >= w) ? 0 : (a >> b);
            8: begin v = a * b; c = ((v >> w) != 0); v = v & m; r.lat = w; end
            9: if (b == 0) begin v = m; er = 1; end else begin v = a / b; r.lat = w; end
            10: if (b == 0) begin v = a; er = 1; end else begin v = a % b; r.lat = w; end
            11: v = (a < b) ? 1 : 0;
            default: begin v = 0; er = 1; end
        endcase
        r.res = v;
        r.flg = {(v == 0), c, ov, er};
        return r;
    endfunction

    // Monitor / scoreboard
    initial begin
        int   bcnt [3];
        bit   pdone [3];
        exp_t it;
        for (int k = 0; k < 3; k++) begin bcnt[k] = 0; pdone[k] = 0; end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (reset) begin
                    bcnt[k]  = 0;
                    pdone[k] = 0;
                end else begin
                    if (bsy[k]) bcnt[k]++;
                    if (dn[k] && !pdone[k]) begin
                        if (sbq.size() == 0) begin
                            total++;
                            $display("FAIL sb_underflow: dut%0d raised done with no expected entry", k);
                        end else begin
                            it = sbq.pop_front();
                            chk($sformatf("sb_dut%0d_index", k), k, it.k);
                            chk($sformatf("sb_dut%0d_result", k), o_res[k], it.res);
                            chk($sformatf("sb_dut%0d_flags", k), {fz[k], fc[k], fv[k], fe[k]}, it.flg);
                            chk($sformatf("sb_dut%0d_busy_cycles", k), bcnt[k], it.lat);
                        end
                        bcnt[k] = 0;
                    end
                    pdone[k] = dn[k];
                end
            end
        end
    end

    task automatic check_cleared(input string tag, input int k);
        chk({tag, "_phase"},  ph[k], 0);
        chk({tag, "_result"}, o_res[k], 0);
        chk({tag, "_regs"},   o_ra[k] | o_rb[k], 0);
        chk({tag, "_flags"},  {fz[k], fc[k], fv[k], fe[k]}, 0);
        chk({tag, "_busy_done"}, {bsy[k], dn[k]}, 0);
    endtask

    // endmode 0: plain step out of DONE; 1: clear together with step.
    task automatic run_seq(input int k, input longint a_in, input longint b_in,
                           input int op_in, input bit exec_step, input int endmode);
        int     w;
        longint m, a, b;
        exp_t   it;
        bit     got;
        w = wid(k);
        m = (longint'(1) << w) - 1;
        a = a_in & m;
        b = b_in & m;
        it = model(w, a, b, op_in);
        it.k = k;
        @(negedge clk);
        chk("start_phase", ph[k], 0);
        din = 16'(a); stp[k] = 1'b1;
        @(negedge clk);
        stp[k] = 1'b0; din = 16'($urandom); opv = 4'($urandom);
        @(negedge clk);
        chk("phase_load_b", ph[k], 1);
        din = 16'(b); opv = 4'(op_in); stp[k] = 1'b1;
        sbq.push_back(it);
        @(negedge clk);
        stp[k] = 1'b0; din = 16'($urandom); opv = 4'($urandom);
        chk("busy_after_b", bsy[k], 1);
        if (exec_step) stp[k] = 1'b1;
        got = 0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            stp[k] = 1'b0;
            if (dn[k]) begin got = 1; break; end
        end
        if (!got) begin
            total++;
            $display("FAIL done_timeout: dut%0d op %0d never reached DONE", k, op_in);
        end
        chk("reg_a_held", o_ra[k], a);
        chk("reg_b_held", o_rb[k], b);
        chk("phase_done", ph[k], 3);
        @(negedge clk);
        stp[k] = 1'b1;
        if (endmode == 1) clr = 1'b1;
        @(negedge clk);
        stp[k] = 1'b0; clr = 1'b0;
        check_cleared((endmode == 1) ? "clear_step" : "step_out", k);
    endtask

    task automatic reset_mid_mul();
        @(negedge clk);
        din = 16'd15; stp[0] = 1'b1;
        @(negedge clk);
        stp[0] = 1'b0;
        @(negedge clk);
        din = 16'd17; opv = 4'd8; stp[0] = 1'b1;
        @(negedge clk);
        stp[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", bsy[0], 1);
        #2 reset = 1'b1;
        #1;
        check_cleared("async_reset", 0);
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        longint a, b;
        int     op, w;
        reset = 1'b1; clr = 1'b0; stp = '0; opv = '0; din = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) check_cleared("reset", k);
        #2 reset = 1'b0;

        // WIDTH=8 directed cases
        run_seq(0, 200, 100, 0, 0, 0);
        run_seq(0, 8'h80, 8'h01, 1, 0, 0);
        run_seq(0, 15, 17, 8, 1, 0);
        run_seq(0, 16, 16, 8, 0, 0);
        run_seq(0, 100, 7, 9, 0, 0);
        run_seq(0, 100, 7, 10, 1, 0);
        run_seq(0, 5, 0, 9, 0, 0);
        run_seq(0, 5, 0, 10, 0, 0);
        run_seq(0, 0, 0, 10, 0, 0);
        run_seq(0, 8'h3C, 8, 6, 0, 0);
        run_seq(0, 8'hF0, 9, 7, 0, 0);
        run_seq(0, 8'hF0, 7, 7, 0, 0);
        run_seq(0, 33, 44, 13, 1, 1);
        reset_mid_mul();
        run_seq(0, 15, 17, 8, 0, 0);

        // WIDTH=16 and WIDTH=4 ADD/MUL
        run_seq(1, 200, 100, 0, 0, 0);
        run_seq(1, 16'hFFFF, 2, 0, 0, 0);
        run_seq(1, 15, 17, 8, 0, 0);
        run_seq(1, 300, 300, 8, 1, 0);
        run_seq(2, 12, 5, 0, 0, 0);
        run_seq(2, 7, 1, 0, 0, 0);
        run_seq(2, 3, 5, 8, 0, 0);
        run_seq(2, 4, 4, 8, 0, 1);

        // Randomized sequences across all widths
        for (int i = 0; i < 60; i++) begin
            int k;
            k  = (i < 30) ? 0 : ((i < 45) ? 1 : 2);
            w  = wid(k);
            a  = longint'($urandom);
            if ($urandom_range(0, 3) == 0) b = longint'($urandom_range(0, w + 2));
            else b = longint'($urandom);
            op = int'($urandom_range(0, 15));
            run_seq(k, a, b, op, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        chk("sb_leftover", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
        $fatal(1, "watchdog");
    end

endmodule
